// File: rtl/uart_line_rx.sv
// uart_line_rx: assembles raw UART receive bytes into LF-terminated lines and
// presents each finished line on a valid/ready stream. The packing is the same
// as the string-iterator message format (first char in the top byte, unused
// bytes zero), so a received line can be fed straight back to the transmit path.
//
// Optional feature macro: UART_LINE_RX_EDIT_EN
//   defined   -> 0x08 (BS) and 0x7F (DEL) remove the last stored character
//   undefined -> 0x08 / 0x7F are stored as ordinary data
//
// Ports
//   clk, rst_n   clock; synchronous active-low reset
//   urx_valid    one-cycle strobe, urx_data holds a received byte
//   urx_data     received byte
//   m_valid      finished line available
//   m_msg        line text, first char in [MSG_WIDTH-1 -: 8], unused bytes zero
//   m_len        characters in m_msg (0..MAX_LINE_LEN)
//   m_overflow   line was longer than MAX_LINE_LEN; excess chars dropped
//   m_dropped    one or more whole lines were lost before this one
//   m_ready      consumer accepts the line

// One character slot of the assembly buffer.
module uart_line_rx_lane (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       wr,
  input  logic [7:0] din,
  output logic [7:0] q
);
  always_ff @(posedge clk) begin
    if (!rst_n || clr) q <= 8'h00;
    else if (wr)       q <= din;
  end
endmodule

module uart_line_rx #(
  parameter  int MAX_LINE_LEN = 128,
  localparam int MSG_WIDTH    = 8 * MAX_LINE_LEN,
  localparam int LEN_WIDTH    = $clog2(MAX_LINE_LEN + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 urx_valid,
  input  logic [7:0]           urx_data,
  output logic                 m_valid,
  output logic [MSG_WIDTH-1:0] m_msg,
  output logic [LEN_WIDTH-1:0] m_len,
  output logic                 m_overflow,
  output logic                 m_dropped,
  input  logic                 m_ready
);

  localparam logic [LEN_WIDTH-1:0] FULL = LEN_WIDTH'(MAX_LINE_LEN);

  // Assembly buffer: abuf[MAX_LINE_LEN-1] is the first character (MSB).
  logic [MAX_LINE_LEN-1:0][7:0] abuf;
  logic [LEN_WIDTH-1:0]         acnt;
  logic                         aovf;
  logic                         dropped;

  // Byte classification
  logic is_cr, is_lf, is_edit;
  logic store, ovf_byte, del, commit, slot_free, load;
  logic [7:0] lane_din;

  assign is_cr = (urx_data == 8'h0D);
  assign is_lf = (urx_data == 8'h0A);
`ifdef UART_LINE_RX_EDIT_EN
  assign is_edit = (urx_data == 8'h08) || (urx_data == 8'h7F);
`else
  assign is_edit = 1'b0;
`endif

  always_comb begin
    store    = 1'b0;
    ovf_byte = 1'b0;
    del      = 1'b0;
    commit   = 1'b0;
    if (urx_valid) begin
      if (is_lf)                     commit   = 1'b1;
      else if (is_edit)              del      = (acnt != '0);
      else if (!is_cr && acnt != FULL) store  = 1'b1;
      else if (!is_cr)               ovf_byte = 1'b1;
    end
  end

  // The output slot can take a line if it is empty or draining this cycle.
  assign slot_free = !m_valid || m_ready;
  assign load      = commit && slot_free;
  assign lane_din  = del ? 8'h00 : urx_data;

  // Slot i (counted from the first character) sits at abuf[MAX_LINE_LEN-1-i].
  // A store writes slot acnt; an edit zeroes slot acnt-1.
  genvar i;
  generate
    for (i = 0; i < MAX_LINE_LEN; i++) begin : g_lane
      logic wr;
      assign wr = (store && acnt == LEN_WIDTH'(i)) ||
                  (del   && acnt == LEN_WIDTH'(i + 1));
      uart_line_rx_lane u_lane (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (commit),
        .wr    (wr),
        .din   (lane_din),
        .q     (abuf[MAX_LINE_LEN-1-i])
      );
    end
  endgenerate

  // Count and overflow flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acnt <= '0;
      aovf <= 1'b0;
    end else if (commit) begin
      acnt <= '0;
      aovf <= 1'b0;
    end else if (store) begin
      acnt <= acnt + LEN_WIDTH'(1);
    end else if (ovf_byte) begin
      aovf <= 1'b1;
    end else if (del) begin
      acnt <= acnt - LEN_WIDTH'(1);
    end
  end

  // Output register. A commit into a busy slot loses the line and marks
  // the next delivered line as having had predecessors dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_valid    <= 1'b0;
      m_msg      <= '0;
      m_len      <= '0;
      m_overflow <= 1'b0;
      m_dropped  <= 1'b0;
      dropped    <= 1'b0;
    end else if (load) begin
      m_valid    <= 1'b1;
      m_msg      <= abuf;
      m_len      <= acnt;
      m_overflow <= aovf;
      m_dropped  <= dropped;
      dropped    <= 1'b0;
    end else begin
      if (m_valid && m_ready) m_valid <= 1'b0;
      if (commit)             dropped <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_line_rx.sv
module tb_uart_line_rx;

  localparam int N  = 4;
  localparam int MW = 8 * N;
  localparam int LW = $clog2(N + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          urx_valid;
  logic [7:0]    urx_data;
  logic          m_valid;
  logic [MW-1:0] m_msg;
  logic [LW-1:0] m_len;
  logic          m_overflow;
  logic          m_dropped;
  logic          m_ready;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  uart_line_rx #(.MAX_LINE_LEN(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .urx_valid  (urx_valid),
    .urx_data   (urx_data),
    .m_valid    (m_valid),
    .m_msg      (m_msg),
    .m_len      (m_len),
    .m_overflow (m_overflow),
    .m_dropped  (m_dropped),
    .m_ready    (m_ready)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive one byte for one cycle; called and returns at a negedge.
  task automatic send(input logic [7:0] b);
    urx_valid = 1'b1;
    urx_data  = b;
    @(negedge clk);
    urx_valid = 1'b0;
    urx_data  = 8'h00;
  endtask

  task automatic send_str(input string s);
    for (int k = 0; k < s.len(); k++) send(s[k]);
  endtask

  task automatic chk_line(input string tag, input logic [LW-1:0] len,
                          input logic [MW-1:0] msg, input logic ovf, input logic drp);
    chk({tag, ".valid"}, m_valid, 1'b1);
    chk({tag, ".len"},   m_len, len);
    chk({tag, ".msg"},   m_msg, msg);
    chk({tag, ".ovf"},   m_overflow, ovf);
    chk({tag, ".drop"},  m_dropped, drp);
  endtask

  initial begin
    rst_n = 1'b0; urx_valid = 1'b0; urx_data = 8'h00; m_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst.valid", m_valid, 1'b0);
    chk("rst.msg",   m_msg, '0);
    chk("rst.len",   m_len, '0);
    chk("rst.ovf",   m_overflow, 1'b0);
    chk("rst.drop",  m_dropped, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // "Hi\r\n": 1-cycle latency, one pulse
    send_str("Hi"); send(8'h0D);
    chk("hi.pre_lf", m_valid, 1'b0);
    send(8'h0A);
    chk_line("hi", 3'd2, 32'h4869_0000, 1'b0, 1'b0);
    @(negedge clk);
    chk("hi.pulse", m_valid, 1'b0);

    // empty line
    send(8'h0A);
    chk_line("empty", 3'd0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);

    // overflow, then next line clean
    send_str("ABCDEF"); send(8'h0A);
    chk_line("ovf", 3'd4, 32'h4142_4344, 1'b1, 1'b0);
    send_str("X"); send(8'h0A);
    chk_line("ovf_next", 3'd1, 32'h5800_0000, 1'b0, 1'b0);
    @(negedge clk);

    // raw bytes 0x00 / 0xFF stored verbatim
    send(8'h00); send(8'hFF); send(8'h0A);
    chk_line("raw", 3'd2, 32'h00FF_0000, 1'b0, 1'b0);
    @(negedge clk);

    // backpressure: B and C lost, D flagged dropped
    m_ready = 1'b0;
    send_str("A"); send(8'h0A);
    send_str("B"); send(8'h0A);
    send_str("C"); send(8'h0A);
    chk_line("hold", 3'd1, 32'h4100_0000, 1'b0, 1'b0);
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    chk("hold.drain", m_valid, 1'b0);
    send_str("D"); send(8'h0A);
    chk_line("drop", 3'd1, 32'h4400_0000, 1'b0, 1'b1);
    m_ready = 1'b1;
    send_str("E"); send(8'h0A);
    chk_line("drop_clr", 3'd1, 32'h4500_0000, 1'b0, 1'b0);
    @(negedge clk);

    // transfer and commit in the same cycle: no bubble
    m_ready = 1'b0;
    send_str("P"); send(8'h0A);
    send_str("Q");
    m_ready = 1'b1;
    send(8'h0A);
    chk_line("b2b", 3'd1, 32'h5100_0000, 1'b0, 1'b0);
    @(negedge clk);
    chk("b2b.end", m_valid, 1'b0);

    // reset mid-line with a line pending on the output
    m_ready = 1'b0;
    send_str("Z"); send(8'h0A);
    send_str("AB");
    rst_n = 1'b0;
    @(negedge clk);
    chk("mrst.valid", m_valid, 1'b0);
    chk("mrst.msg",   m_msg, '0);
    chk("mrst.len",   m_len, '0);
    rst_n = 1'b1; m_ready = 1'b1;
    send_str("C"); send(8'h0A);
    chk_line("mrst", 3'd1, 32'h4300_0000, 1'b0, 1'b0);
    @(negedge clk);

    // BS / DEL handling
    send_str("AB"); send(8'h08); send_str("C"); send(8'h0A);
`ifdef UART_LINE_RX_EDIT_EN
    chk_line("bs", 3'd2, 32'h4143_0000, 1'b0, 1'b0);
`else
    chk_line("bs", 3'd4, 32'h4142_0843, 1'b0, 1'b0);
`endif
    @(negedge clk);
    send(8'h7F); send(8'h0A);
`ifdef UART_LINE_RX_EDIT_EN
    chk_line("del0", 3'd0, 32'h0, 1'b0, 1'b0);
`else
    chk_line("del0", 3'd1, 32'h7F00_0000, 1'b0, 1'b0);
`endif
    @(negedge clk);
    send_str("ABC"); send(8'h08); send(8'h0A);
`ifdef UART_LINE_RX_EDIT_EN
    chk_line("bs_zero", 3'd2, 32'h4142_0000, 1'b0, 1'b0);
`else
    chk_line("bs_zero", 3'd4, 32'h4142_4308, 1'b0, 1'b0);
`endif
    @(negedge clk);
    send_str("ABCDE"); send(8'h7F); send(8'h0A);
`ifdef UART_LINE_RX_EDIT_EN
    chk_line("del_ovf", 3'd3, 32'h4142_4300, 1'b1, 1'b0);
`else
    chk_line("del_ovf", 3'd4, 32'h4142_4344, 1'b1, 1'b0);
`endif
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
